// File: rtl/truth_table_scanner.sv
// Sweeps every input vector of an N-input combinational function, captures its
// truth table and compares it against a reference constant.
module truth_table_scanner #(
    parameter int                N        = 4,
    parameter int                SETTLE   = 0,
    parameter logic [2**N-1:0]   EXPECTED = 16'h0AC5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N-1:0]      x_out,
    input  logic              z_in,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   table_out,
    output logic              match,
    output logic [N:0]        mismatch_cnt,
    output logic              fail_valid,
    output logic [N-1:0]      first_fail
);

    // state    | meaning
    // S_IDLE   | waiting for start, results held
    // S_SETTLE | new vector applied, waiting SETTLE cycles
    // S_SAMPLE | capture z_in for current vector, advance
    // S_DONE   | sweep finished, result flags computed next edge

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [7:0]   SETTLE_L = 8'(SETTLE);
    localparam logic [N-1:0] X_MAX    = '1;

    state_t     state;
    logic [7:0] settle_cnt;

    // busy/done are registered decodes of the state, so they trail it by one
    // cycle; this places done right after the last sampled vector's cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            settle_cnt   <= '0;
            x_out        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_out    <= '0;
            match        <= 1'b0;
            mismatch_cnt <= '0;
            fail_valid   <= 1'b0;
            first_fail   <= '0;
        end else begin
            busy <= (state == S_SETTLE) || (state == S_SAMPLE);
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_out        <= '0;
                        table_out    <= '0;
                        mismatch_cnt <= '0;
                        fail_valid   <= 1'b0;
                        first_fail   <= '0;
                        match        <= 1'b0;
                        settle_cnt   <= SETTLE_L;
                        state        <= (SETTLE_L != 8'd0) ? S_SETTLE : S_SAMPLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt <= 8'd1) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    table_out[x_out] <= z_in;
                    if (z_in != EXPECTED[x_out]) begin
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            first_fail <= x_out;
                        end
                    end
                    if (x_out == X_MAX) begin
                        state <= S_DONE;
                    end else begin
                        x_out      <= x_out + 1'b1;
                        settle_cnt <= SETTLE_L;
                        state      <= (SETTLE_L != 8'd0) ? S_SETTLE : S_SAMPLE;
                    end
                end
                S_DONE: begin
                    match <= (mismatch_cnt == '0);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: MDNF network, stuck-at outputs,
// settle delay, mid-sweep reset and continuous start.
module tb_truth_table_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;

    logic        start0, busy0, done0, match0, fv0, z0;
    logic [3:0]  x0, ff0;
    logic [15:0] tab0;
    logic [4:0]  mc0;

    logic        start2, busy2, done2, match2, fv2, z2;
    logic [3:0]  x2, ff2;
    logic [15:0] tab2;
    logic [4:0]  mc2;

    int checks = 0;
    int errors = 0;
    int cyc;

    always #5 clk = ~clk;

    // Gate-level MDNF of minterms 0,2,6,7,9,11
    function automatic logic mdnf(input logic [3:0] x);
        return (~x[3] & ~x[2] & ~x[0]) | (~x[3] & x[2] & x[1]) | (x[3] & ~x[2] & x[0]);
    endfunction

    assign z0 = (mode == 2'd0) ? mdnf(x0) : (mode == 2'd2);
    assign z2 = mdnf(x2);

    truth_table_scanner #(.N(4), .SETTLE(0), .EXPECTED(16'h0AC5)) d0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .x_out(x0), .z_in(z0),
        .busy(busy0), .done(done0), .table_out(tab0), .match(match0),
        .mismatch_cnt(mc0), .fail_valid(fv0), .first_fail(ff0)
    );

    truth_table_scanner #(.N(4), .SETTLE(2), .EXPECTED(16'h0AC5)) d2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .x_out(x2), .z_in(z2),
        .busy(busy2), .done(done2), .table_out(tab2), .match(match2),
        .mismatch_cnt(mc2), .fail_valid(fv2), .first_fail(ff2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] t, input logic [4:0] mc,
                             input logic fv, input logic [3:0] ff, input logic m);
        check({tag, "_table"}, 32'(tab0), 32'(t));
        check({tag, "_mcnt"},  32'(mc0),  32'(mc));
        check({tag, "_fv"},    32'(fv0),  32'(fv));
        check({tag, "_ff"},    32'(ff0),  32'(ff));
        check({tag, "_match"}, 32'(match0), 32'(m));
    endtask

    // Start pulse on d0, then count edges until done is seen.
    task automatic sweep0(input string tag, output int n);
        @(negedge clk) start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        check({tag, "_busy_e0"}, 32'(busy0), 32'd0);
        n = 0;
        while (!done0 && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check({tag, "_busy_e1"}, 32'(busy0), 32'd1);
        end
        check({tag, "_done_cyc"}, 32'(n), 32'd17);
        check({tag, "_busy_at_done"}, 32'(busy0), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'd0; start0 = 1'b0; start2 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_x",    32'(x0),   32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check_res("rst", 16'h0000, 5'd0, 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        mode = 2'd0;
        sweep0("mdnf", cyc);
        check_res("mdnf", 16'h0AC5, 5'd0, 1'b0, 4'd0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_done",  32'(done0), 32'd0);
        check("hold_x",     32'(x0),    32'd15);
        check("hold_table", 32'(tab0),  32'h0AC5);
        check("hold_match", 32'(match0), 32'd1);

        mode = 2'd1;
        sweep0("zero", cyc);
        check_res("zero", 16'h0000, 5'd6, 1'b1, 4'd0, 1'b0);

        mode = 2'd2;
        sweep0("one", cyc);
        check_res("one", 16'hFFFF, 5'd10, 1'b1, 4'd1, 1'b0);

        // SETTLE=2 instance: 3 cycles per vector
        @(negedge clk) start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 5) check("s2_x_e5", 32'(x2), 32'd1);
            if (cyc == 6) check("s2_x_e6", 32'(x2), 32'd2);
        end
        check("s2_done_cyc", 32'(cyc),   32'd49);
        check("s2_table",    32'(tab2),  32'h0AC5);
        check("s2_match",    32'(match2), 32'd1);
        check("s2_mcnt",     32'(mc2),   32'd0);

        // Restart attempt mid-sweep, then reset at x_out=9
        mode = 2'd0;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        check("restart_ignored_x", 32'(x0), 32'd6);
        cyc = 0;
        while (x0 != 4'd9 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_x9", 32'(x0), 32'd9);
        rst_n = 1'b0;
        #1;
        check("abort_x",    32'(x0),    32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        check_res("abort", 16'h0000, 5'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done0), 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        sweep0("fresh", cyc);
        check_res("fresh", 16'h0AC5, 5'd0, 1'b0, 4'd0, 1'b1);

        // start held high: back-to-back sweeps
        @(negedge clk) start0 = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (!done0 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("held1_done_cyc", 32'(cyc), 32'd17);
        check_res("held1", 16'h0AC5, 5'd0, 1'b0, 4'd0, 1'b1);
        @(posedge clk); #1;
        check("held_gap_busy", 32'(busy0), 32'd0);
        check("held_gap_done", 32'(done0), 32'd0);
        @(posedge clk); #1;
        check("held_busy_rise", 32'(busy0), 32'd1);
        cyc = 19;
        while (!done0 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("held2_done_cyc", 32'(cyc), 32'd35);
        check_res("held2", 16'h0AC5, 5'd0, 1'b0, 4'd0, 1'b1);
        @(negedge clk) start0 = 1'b0;
        repeat (40) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
